// File: rtl/uart_rx_ctrl.sv
// Receiver sequencing/buffering: enable/flush FSM, rising-edge byte capture into a FWFT FIFO.
// Optional idle-timeout pulse is built only when UART_RX_TIMEOUT_EN is defined.
module uart_rx_ctrl #(
  parameter int DEPTH        = 4,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     rxDone,
  input  logic [7:0]               rxByte,
  output logic                     rxRst,
  output logic                     outValid,
  output logic [7:0]               outData,
  input  logic                     outReady,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     clearOverflow,
  output logic                     idleTimeout
);

  localparam int PW     = $clog2(DEPTH);
  localparam int CW     = PW + 1;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {DISABLED, FLUSH, ACTIVE} state_t;

  state_t state, state_nxt;
  logic   flush_cnt, flush_cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= DISABLED;
      flush_cnt <= 1'b0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = 1'b0;
    case (state)
      DISABLED: if (enable) state_nxt = FLUSH;
      FLUSH: begin
        if (!enable)        state_nxt = DISABLED;
        else if (flush_cnt) state_nxt = ACTIVE;
        else                flush_cnt_nxt = 1'b1;
      end
      ACTIVE:   if (!enable) state_nxt = DISABLED;
      default:  state_nxt = DISABLED;
    endcase
  end

  logic active;
  assign active = (state == ACTIVE);
  assign rxRst  = rst | ~active;

  // Capture stage: one push per rising edge of rxDone, only while the receiver runs
  logic rx_done_prev;
  logic push, pop, full, wr_en, drop;

  always_ff @(posedge clk) begin
    if (rst) rx_done_prev <= 1'b0;
    else     rx_done_prev <= active & rxDone;
  end

  assign push     = active & rxDone & ~rx_done_prev;
  assign outValid = (count != '0);
  assign pop      = outValid & outReady;
  assign full     = (count == CW'(DEPTH));
  assign wr_en    = push & (~full | pop);
  assign drop     = push & full & ~pop;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= rxByte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset, so mask the head while empty to keep a clean zero
  assign outData = outValid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst)                overflow <= 1'b0;
    else if (clearOverflow) overflow <= 1'b0;
    else if (drop)          overflow <= 1'b1;
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);

  logic [IW-1:0] idle_cnt;
  logic          idle_pulse;
  logic          idle_clr;

  assign idle_clr = push | (count == '0) | ~active;

  // Counter parks at IDLE_TIMEOUT so each idle period yields a single pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt   <= '0;
      idle_pulse <= 1'b0;
    end else if (idle_clr) begin
      idle_cnt   <= '0;
      idle_pulse <= 1'b0;
    end else begin
      idle_pulse <= (idle_cnt == IW'(IDLE_TIMEOUT - 1));
      if (idle_cnt != IW'(IDLE_TIMEOUT)) idle_cnt <= idle_cnt + IW'(1);
    end
  end

  assign idleTimeout = idle_pulse;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (IDLE_TIMEOUT < 2);
  assign idleTimeout        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: directed scenarios followed by randomized traffic.
module tb_uart_rx_ctrl;
  localparam int DEPTH        = 4;
  localparam int IDLE_TIMEOUT = 16;
`ifdef UART_RX_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst, enable, rxDone, outReady, clearOverflow;
  logic [7:0]             rxByte;
  logic                   rxRst, outValid, overflow, idleTimeout;
  logic [7:0]             outData;
  logic [$clog2(DEPTH):0] count;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.DEPTH(DEPTH), .IDLE_TIMEOUT(IDLE_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .enable(enable), .rxDone(rxDone), .rxByte(rxByte),
    .rxRst(rxRst), .outValid(outValid), .outData(outData), .outReady(outReady),
    .count(count), .overflow(overflow), .clearOverflow(clearOverflow),
    .idleTimeout(idleTimeout)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: bytes expected from the FIFO in order, plus link/flag state
  logic [7:0] exp_q[$];
  int  run = 0;          // consecutive edges sampled with enable=1 (capped at 3)
  int  cyc = 0;
  int  last_clear = 0;   // last edge at which the idle period restarted
  bit  prev_done = 0, ovf = 0, exp_pulse = 0, pop_pending = 0, mon_on = 0;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        exp_q.delete();
        run = 0; prev_done = 0; ovf = 0; exp_pulse = 0;
        last_clear = cyc; pop_pending = 0; mon_on = 1;
      end else begin
        bit act, push, clr;
        int occ;
        act  = (run >= 3);
        occ  = exp_q.size() + (pop_pending ? 1 : 0);
        push = act && rxDone && !prev_done;
        if (push) begin
          if (occ < DEPTH || pop_pending) exp_q.push_back(rxByte);
          else if (!clearOverflow)        ovf = 1;
        end
        if (clearOverflow) ovf = 0;
        clr = push || (occ == 0) || !act;
        if (clr) last_clear = cyc;
        exp_pulse = TIMEOUT_EN && !clr && (cyc - last_clear == IDLE_TIMEOUT);
        prev_done = act && rxDone;
        run = enable ? ((run < 3) ? run + 1 : 3) : 0;
        pop_pending = 0;
      end
    end
  end

  // Monitor: compares every cycle, pops the expected head on each handshake
  initial begin
    forever begin
      @(negedge clk);
      if (mon_on) begin
        chk("rxRst", rxRst, (rst || run < 3));
        chk("outValid", outValid, (exp_q.size() != 0));
        chk("count", count, exp_q.size());
        chk("overflow", overflow, ovf);
        chk("idleTimeout", idleTimeout, exp_pulse);
        if (exp_q.size() > 0 && outReady) begin
          chk("outData", outData, exp_q[0]);
          void'(exp_q.pop_front());
          pop_pending = 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rxDone = 1'b1; rxByte = b;
    tick();
    rxDone = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; rxDone = 1'b0; rxByte = 8'h00;
    outReady = 1'b0; clearOverflow = 1'b0;
    tick(); tick();
    chk("rst_outData", outData, 8'h00);
    chk("rst_count", count, 0);
    chk("rst_rxRst", rxRst, 1);
    rst = 1'b0;
    tick(); tick();
    chk("flush_rxRst", rxRst, 1);
    tick();
    chk("active_rxRst", rxRst, 0);

    send(8'hA5); send(8'h3C);
    chk("two_count", count, 2);
    chk("two_head", outData, 8'hA5);
    outReady = 1'b1; tick(); outReady = 1'b0;
    chk("one_head", outData, 8'h3C);
    chk("one_count", count, 1);
    outReady = 1'b1; tick(); outReady = 1'b0;

    for (int i = 1; i <= 5; i++) send(8'(i));
    chk("ovf_count", count, DEPTH);
    chk("ovf_flag", overflow, 1);
    outReady = 1'b1; repeat (4) tick(); outReady = 1'b0;
    chk("drain_count", count, 0);
    clearOverflow = 1'b1; tick(); clearOverflow = 1'b0;
    chk("ovf_clear", overflow, 0);

    for (int i = 0; i < 4; i++) send(8'h11 + 8'(i));
    rxDone = 1'b1; rxByte = 8'h99; outReady = 1'b1;
    tick();
    rxDone = 1'b0; outReady = 1'b0;
    chk("pushpop_count", count, DEPTH);
    chk("pushpop_ovf", overflow, 0);
    outReady = 1'b1; repeat (3) tick();
    chk("last_is_99", outData, 8'h99);
    tick(); outReady = 1'b0;

    rxDone = 1'b1; rxByte = 8'h55;
    repeat (3) tick();
    rxDone = 1'b0; tick();
    chk("held_done_count", count, 1);
    send(8'h77);
    enable = 1'b0; tick();
    chk("disable_rxRst", rxRst, 1);
    outReady = 1'b1; tick();
    chk("disabled_read", outData, 8'h77);
    tick(); outReady = 1'b0;
    chk("disabled_empty", count, 0);

    enable = 1'b1; repeat (3) tick();
    send(8'hC3);
    repeat (20) tick();
    outReady = 1'b1; tick(); outReady = 1'b0;
    repeat (20) tick();

    for (int blk = 0; blk < 20; blk++) begin
      int rdy_pct;
      rdy_pct = $urandom_range(5, 95);
      for (int c = 0; c < 200; c++) begin
        rst           = ($urandom_range(0, 399) == 0);
        enable        = ($urandom_range(0, 29) != 0);
        rxDone        = ($urandom_range(0, 2) == 0);
        rxByte        = 8'($urandom);
        outReady      = ($urandom_range(0, 99) < rdy_pct);
        clearOverflow = ($urandom_range(0, 40) == 0);
        tick();
      end
    end
    rst = 1'b0; enable = 1'b0; rxDone = 1'b0; outReady = 1'b0; clearOverflow = 1'b0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Sequencing and buffering controller for the UART receiver. It holds the receiver in reset while the link is disabled and runs a flush sequence on enable. It captures each completed byte on the receiver's `done` pulse into a small first-word-fall-through FIFO and presents the bytes to the consumer over a valid/ready handshake. It sits directly between the receiver instance and the host-side logic, and reports overflow and line-idle events.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `IDLE_TIMEOUT`, default 16: cycles without a new byte, while the FIFO is non-empty, before `idleTimeout` pulses; ≥2.

Ports:
- `clk`  in  1  single clock, all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  link enable from the host.
- `rxDone`  in  1  receiver `done`.
- `rxByte`  in  8  receiver `byteRecieved`.
- `rxRst`  out  1  drives the receiver's `rst`.
- `outValid`  out  1  FIFO head valid.
- `outData`  out  8  FIFO head byte.
- `outReady`  in  1  consumer accepts the head.
- `count`  out  $clog2(DEPTH)+1  current occupancy.
- `overflow`  out  1  sticky: a byte was dropped.
- `clearOverflow`  in  1  clears `overflow`.
- `idleTimeout`  out  1  one-cycle idle pulse (only with the macro enabled).

## Operation
- State machine, reset state DISABLED:
  - DISABLED: go to FLUSH when `enable`=1.
  - FLUSH: lasts exactly 2 cycles, then goes to ACTIVE. If `enable` drops during FLUSH, return to DISABLED.
  - ACTIVE: go to DISABLED when `enable`=0.
- `rxRst` = `rst` OR (state ≠ ACTIVE), combinational. The receiver runs only in ACTIVE.
- Capture:
  - `rxDonePrev` is registered each cycle.
  - Push when state=ACTIVE AND `rxDone`=1 AND `rxDonePrev`=0. `rxByte` is sampled in that same cycle.
  - `rxDonePrev` is forced to 0 outside ACTIVE.
- Pop when `outValid` AND `outReady`.
- `outValid` = (`count` ≠ 0). `outData` = the entry at the read pointer; its value is don't-care while `outValid`=0.
- FIFO pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. `count` saturates in neither direction; it is exact.
- Full (`count`=DEPTH):
  - Push without pop: byte dropped, `overflow`←1, pointers and `count` unchanged.
  - Push with pop in the same cycle: both occur, `count` stays DEPTH, no overflow.
- Empty: a pop request is ignored. Push with `outReady`=1 in the same cycle: the push is stored, `count`→1.
- `clearOverflow` takes priority over setting `overflow`: if both occur in one cycle, `overflow`=0 and the byte is still dropped.
- Leaving ACTIVE does not clear the FIFO. Buffered bytes stay readable in DISABLED and FLUSH.
- `rst` mid-operation: FIFO emptied, pending bytes lost, all state reinitialised on the next edge.

## Timing
- Reset values: `rxRst`=1, `outValid`=0, `outData`=8'h00, `count`=0, `overflow`=0, `idleTimeout`=0, state DISABLED.
- Enable latency: `enable` sampled high at edge E. FLUSH spans edges E+1 and E+2. `rxRst` falls after edge E+2.
- Capture latency: `rxDone` rising sampled at edge N. `outValid`=1 and `outData`=`rxByte` are visible after edge N.
- Pop at edge P: the next head, or `outValid`=0, is visible after edge P.
- `count` updates on the same edge as the push or pop.

## Configuration
- `UART_RX_TIMEOUT_EN` defined:
  - An idle counter clears on every push and whenever the FIFO is empty or state ≠ ACTIVE.
  - Otherwise it increments each cycle.
  - When it reaches `IDLE_TIMEOUT`, `idleTimeout` is high for exactly one cycle. The counter then holds until cleared, so there is one pulse per idle period.
- `UART_RX_TIMEOUT_EN` undefined:
  - No counter is built.
  - The `idleTimeout` port remains and is tied to 0.

## Test plan
- Reset with `enable`=1 held: `rxRst`=1 for the reset cycle plus 2 FLUSH cycles, then 0. All other outputs are at reset values throughout.
- ACTIVE; `rxDone` pulses with `rxByte`=8'hA5, then 8'h3C; `outReady`=0 → `count`=2, `outData`=8'hA5. One `outReady` cycle → `outData`=8'h3C, `count`=1.
- DEPTH=4; 5 bytes 8'h01..8'h05 with no reads → `count`=4, `overflow`=1. Drain yields 01,02,03,04. `clearOverflow` → `overflow`=0.
- Full FIFO; push 8'h99 together with a pop → `count` stays 4, no overflow, and 8'h99 is the last byte read out.
- `rxDone` held high for 3 cycles with `rxByte`=8'h55 → exactly one push. Drop `enable` mid-stream → `rxRst`=1 next cycle, and the buffered bytes are still readable.
- With `UART_RX_TIMEOUT_EN` and IDLE_TIMEOUT=16: one byte pushed, no reads → `idleTimeout` pulses once, 16 cycles after the push. No pulse occurs with the FIFO empty, or with the macro undefined.
